// File: rtl/if_stage_pkg.sv
// Shared constants and FSM encoding for the instruction-fetch stage.
package if_stage_pkg;

  localparam int DEF_PC_WIDTH    = 32;
  localparam int DEF_INSTR_WIDTH = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_FETCH   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_DISCARD = 2'd2
  } if_state_t;

endpackage

// File: rtl/if_stage_pc_select.sv
// Next-PC selection: branch beats jump beats sequential; a jump waits out a stall, a branch does not.
module pc_select #(
  parameter int PC_WIDTH = 32
) (
  input  logic [PC_WIDTH-1:0] pc,
  input  logic                stall_pipeline,
  input  logic                is_jump,
  input  logic [PC_WIDTH-1:0] jump_addr,
  input  logic                branch_taken,
  input  logic [PC_WIDTH-1:0] branch_addr,
  output logic                redirect,
  output logic [PC_WIDTH-1:0] target,
  output logic [PC_WIDTH-1:0] pc_seq
);

  always_comb begin
    redirect = 1'b0;
    target   = jump_addr;
    if (branch_taken) begin
      redirect = 1'b1;
      target   = branch_addr;
    end else if (is_jump && !stall_pipeline) begin
      redirect = 1'b1;
      target   = jump_addr;
    end
  end

  assign pc_seq = pc + PC_WIDTH'(1);

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, memory handshake FSM, one-entry skid buffer and IF/ID register.
//
// state      | meaning
// FETCH      | request at PC outstanding (or issued this cycle)
// HOLD       | acked word parked in skid buffer while ID is stalled; no request
// DISCARD    | request for an abandoned address still outstanding; its data is dropped
module if_stage
  import if_stage_pkg::*;
#(
  parameter int PC_WIDTH    = DEF_PC_WIDTH,
  parameter int INSTR_WIDTH = DEF_INSTR_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_pipeline,
  input  logic                   is_jump,
  input  logic [PC_WIDTH-1:0]    jump_addr,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_addr,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_ack,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] out_instruction,
  output logic [PC_WIDTH-1:0]    out_pc,
  output logic                   out_valid
);

  localparam logic [INSTR_WIDTH-1:0] NOP = INSTR_WIDTH'(NOP_INSTR);

  if_state_t state, state_n;

  logic [PC_WIDTH-1:0]    pc, pc_n;
  logic [PC_WIDTH-1:0]    stale_addr, stale_addr_n;
  logic [INSTR_WIDTH-1:0] skid_instr, skid_instr_n;
  logic                   skid_valid, skid_valid_n;
  logic [INSTR_WIDTH-1:0] instr_n;
  logic [PC_WIDTH-1:0]    opc_n;
  logic                   valid_n;

  logic                   redirect;
  logic [PC_WIDTH-1:0]    target;
  logic [PC_WIDTH-1:0]    pc_seq;

  pc_select #(
    .PC_WIDTH(PC_WIDTH)
  ) u_pc_select (
    .pc             (pc),
    .stall_pipeline (stall_pipeline),
    .is_jump        (is_jump),
    .jump_addr      (jump_addr),
    .branch_taken   (branch_taken),
    .branch_addr    (branch_addr),
    .redirect       (redirect),
    .target         (target),
    .pc_seq         (pc_seq)
  );

  // The request stays pinned to the abandoned address until its ack arrives.
  assign imem_req  = !rst && (state != ST_HOLD);
  assign imem_addr = (state == ST_DISCARD) ? stale_addr : pc;

  always_comb begin
    state_n      = state;
    pc_n         = pc;
    stale_addr_n = stale_addr;
    skid_instr_n = skid_instr;
    skid_valid_n = skid_valid;
    instr_n      = out_instruction;
    opc_n        = out_pc;
    valid_n      = out_valid;

    // ID consumes IF/ID every unstalled cycle, so an empty cycle becomes a bubble.
    if (!stall_pipeline) begin
      instr_n = NOP;
      valid_n = 1'b0;
    end

    case (state)
      ST_FETCH: begin
        if (redirect) begin
          pc_n         = target;
          instr_n      = NOP;
          valid_n      = 1'b0;
          skid_valid_n = 1'b0;
          if (!imem_ack) begin
            state_n      = ST_DISCARD;
            stale_addr_n = pc;
          end
        end else if (imem_ack) begin
          if (stall_pipeline) begin
            skid_instr_n = imem_rdata;
            skid_valid_n = 1'b1;
            state_n      = ST_HOLD;
          end else begin
            instr_n = imem_rdata;
            opc_n   = pc;
            valid_n = 1'b1;
            pc_n    = pc_seq;
          end
        end
      end

      ST_HOLD: begin
        if (redirect) begin
          pc_n         = target;
          instr_n      = NOP;
          valid_n      = 1'b0;
          skid_valid_n = 1'b0;
          state_n      = ST_FETCH;
        end else if (!stall_pipeline) begin
          instr_n      = skid_instr;
          opc_n        = pc;
          valid_n      = skid_valid;
          pc_n         = pc_seq;
          skid_valid_n = 1'b0;
          state_n      = ST_FETCH;
        end
      end

      ST_DISCARD: begin
        if (redirect) begin
          pc_n         = target;
          instr_n      = NOP;
          valid_n      = 1'b0;
          skid_valid_n = 1'b0;
        end
        if (imem_ack) begin
          state_n = ST_FETCH;
        end
      end

      default: begin
        state_n = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_FETCH;
      pc              <= '0;
      stale_addr      <= '0;
      skid_instr      <= NOP;
      skid_valid      <= 1'b0;
      out_instruction <= NOP;
      out_pc          <= '0;
      out_valid       <= 1'b0;
    end else begin
      state           <= state_n;
      pc              <= pc_n;
      stale_addr      <= stale_addr_n;
      skid_instr      <= skid_instr_n;
      skid_valid      <= skid_valid_n;
      out_instruction <= instr_n;
      out_pc          <= opc_n;
      out_valid       <= valid_n;
    end
  end

endmodule
